change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_if.sv | 30 +++
 rtl/change_dispenser.sv | 142 ++++++++++++++
 tb/tb_change_dispenser.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Change dispenser bus: transaction request, coin handshake and status.
// master: the vending controller / coin mechanism side (drives req, paid,
//         price, reject, coin_ack).
// slave:  the dispenser (drives busy, coin_valid, coin_value, done,
//         refunded, coin_count).
interface change_dispenser_if;
  localparam int unsigned W = 5;

  logic         req;
  logic [W-1:0] paid;
  logic [W-1:0] price;
  logic         reject;
  logic         busy;
  logic         coin_valid;
  logic [W-1:0] coin_value;
  logic         coin_ack;
  logic         done;
  logic         refunded;
  logic [W-1:0] coin_count;

  modport master (
    output req, paid, price, reject, coin_ack,
    input  busy, coin_valid, coin_value, done, refunded, coin_count
  );

  modport slave (
    input  req, paid, price, reject, coin_ack,
    output busy, coin_valid, coin_value, done, refunded, coin_count
  );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a paid/price/reject transaction, computes the
// change (or the full refund) and hands it out greedily, one coin per
// valid/ack handshake, largest denomination first.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high
//   io     - change_dispenser_if.slave (req/paid/price/reject in,
//            coin_valid/coin_value out with coin_ack in, busy/done/
//            refunded/coin_count status out)
module change_dispenser #(
  parameter int unsigned DENOM_HI  = 10,
  parameter int unsigned DENOM_MID = 5,
  parameter int unsigned DENOM_LO  = 1
) (
  input  logic                clock,
  input  logic                reset,
  change_dispenser_if.slave   io
);
  localparam int unsigned W = 5;

  typedef enum logic [1:0] {IDLE, CALC, DISPENSE, DONE} state_t;

  state_t       state;
  state_t       next_state;

  logic [W-1:0] paid_q;
  logic [W-1:0] price_q;
  logic         reject_q;
  logic [W-1:0] remaining;
  logic [W-1:0] remaining_d;
  logic         refunded_q;
  logic         refunded_d;
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  logic         busy_q;
  logic         busy_d;
  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         done_q;
  logic         done_d;

  logic         accept;
  logic         take;
  logic         refund;
  logic [W-1:0] change;

  // Largest denomination not exceeding the amount still owed.
  function automatic logic [W-1:0] pick_coin(input logic [W-1:0] amt);
    if (amt >= W'(DENOM_HI))  return W'(DENOM_HI);
    if (amt >= W'(DENOM_MID)) return W'(DENOM_MID);
    if (amt >= W'(DENOM_LO))  return W'(DENOM_LO);
    return '0;
  endfunction

  assign accept = (state == IDLE) && io.req;
  // valid_q is high exactly in DISPENSE, so the state stands in for it.
  assign take   = (state == DISPENSE) && io.coin_ack;
  // Underpayment refunds rather than subtracting, so no wrap is possible.
  assign refund = reject_q || (paid_q < price_q);
  assign change = refund ? paid_q : paid_q - price_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (io.req) next_state = CALC;
      CALC:     next_state = (change == '0) ? DONE : DISPENSE;
      DISPENSE: if (take && (remaining == value_q)) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath and output next values; outputs follow next_state so they
  // are registered yet aligned with the state they describe.
  always_comb begin
    remaining_d = remaining;
    count_d     = count_q;
    refunded_d  = refunded_q;
    case (state)
      IDLE:     if (io.req) count_d = '0;
      CALC: begin
        remaining_d = change;
        refunded_d  = refund;
      end
      DISPENSE: if (take) begin
        remaining_d = remaining - value_q;
        count_d     = count_q + W'(1);
      end
      default: ;
    endcase
    busy_d  = (next_state != IDLE);
    valid_d = (next_state == DISPENSE);
    value_d = valid_d ? pick_coin(remaining_d) : '0;
    done_d  = (next_state == DONE);
  end

  // Captured request, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      paid_q     <= '0;
      price_q    <= '0;
      reject_q   <= 1'b0;
      remaining  <= '0;
      refunded_q <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      value_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      if (accept) begin
        paid_q   <= io.paid;
        price_q  <= io.price;
        reject_q <= io.reject;
      end
      remaining  <= remaining_d;
      refunded_q <= refunded_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      value_q    <= value_d;
      done_q     <= done_d;
    end
  end

  assign io.busy       = busy_q;
  assign io.coin_valid = valid_q;
  assign io.coin_value = value_q;
  assign io.done       = done_q;
  assign io.refunded   = refunded_q;
  assign io.coin_count = count_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of transactions with hand-computed
// coin sequences, plus directed sequences for stall, stray ack and
// mid-transaction reset.
module tb_change_dispenser;
  logic clock = 1'b0;
  logic reset = 1'b1;

  change_dispenser_if bus ();

  change_dispenser #(
    .DENOM_HI (10),
    .DENOM_MID(5),
    .DENOM_LO (1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]      paid;
    logic [4:0]      price;
    logic            reject;
    int              ncoins;
    logic [3:0][4:0] coins;
    logic            refunded;
  } vec_t;

  int passed = 0;
  int total  = 0;
  vec_t vecs [9];

  function automatic vec_t mk(input int pa, input int pr, input int rj, input int n,
                              input int c0, input int c1, input int c2, input int c3,
                              input int rf);
    vec_t v;
    v.paid     = 5'(pa);
    v.price    = 5'(pr);
    v.reject   = 1'(rj);
    v.ncoins   = n;
    v.coins[0] = 5'(c0);
    v.coins[1] = 5'(c1);
    v.coins[2] = 5'(c2);
    v.coins[3] = 5'(c3);
    v.refunded = 1'(rf);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One transaction; stall holds coin_ack low on the first coin while
  // stray req pulses are driven.
  task automatic run_txn(input vec_t v, input int stall);
    @(negedge clock);
    bus.req    = 1'b1;
    bus.paid   = v.paid;
    bus.price  = v.price;
    bus.reject = v.reject;
    @(negedge clock);
    bus.req    = 1'b0;
    bus.paid   = '0;
    bus.price  = '0;
    bus.reject = 1'b0;
    check("calc_busy", bus.busy, 1);
    check("calc_valid", bus.coin_valid, 0);
    check("calc_done", bus.done, 0);
    check("calc_count", bus.coin_count, 0);
    @(negedge clock);
    for (int k = 0; k < v.ncoins; k++) begin
      check("coin_valid", bus.coin_valid, 1);
      check("coin_value", bus.coin_value, int'(v.coins[k]));
      check("coin_busy", bus.busy, 1);
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          bus.req   = 1'b1;
          bus.paid  = 5'd31;
          bus.price = 5'd0;
          @(negedge clock);
          check("stall_valid", bus.coin_valid, 1);
          check("stall_value", bus.coin_value, int'(v.coins[0]));
          check("stall_count", bus.coin_count, 0);
        end
        bus.req   = 1'b0;
        bus.paid  = '0;
        bus.price = '0;
      end
      bus.coin_ack = 1'b1;
      @(negedge clock);
      bus.coin_ack = 1'b0;
    end
    check("done_pulse", bus.done, 1);
    check("done_valid", bus.coin_valid, 0);
    check("done_value", bus.coin_value, 0);
    check("done_busy", bus.busy, 1);
    check("done_refunded", bus.refunded, int'(v.refunded));
    check("done_count", bus.coin_count, v.ncoins);
    @(negedge clock);
    check("idle_done", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_refunded", bus.refunded, int'(v.refunded));
    check("idle_count", bus.coin_count, v.ncoins);
    @(negedge clock);
    check("idle2_busy", bus.busy, 0);
    check("idle2_done", bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(20,  5, 0, 2, 10,  5, 0, 0, 0);
    vecs[1] = mk(30, 13, 0, 4, 10,  5, 1, 1, 0);
    vecs[2] = mk(10, 20, 0, 1, 10,  0, 0, 0, 1);
    vecs[3] = mk(20,  5, 1, 2, 10, 10, 0, 0, 1);
    vecs[4] = mk(10, 10, 0, 0,  0,  0, 0, 0, 0);
    vecs[5] = mk(31,  0, 0, 4, 10, 10, 10, 1, 0);
    vecs[6] = mk( 0,  0, 0, 0,  0,  0, 0, 0, 0);
    vecs[7] = mk( 7,  0, 0, 3,  5,  1, 1, 0, 0);
    vecs[8] = mk(16,  0, 1, 3, 10,  5, 1, 0, 1);

    bus.req      = 1'b0;
    bus.paid     = '0;
    bus.price    = '0;
    bus.reject   = 1'b0;
    bus.coin_ack = 1'b0;

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.coin_valid, 0);
    check("rst_value", bus.coin_value, 0);
    check("rst_done", bus.done, 0);
    check("rst_refunded", bus.refunded, 0);
    check("rst_count", bus.coin_count, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(vecs[i], (i == 0) ? 5 : 0);

    // coin_ack with no coin offered changes nothing.
    @(negedge clock);
    bus.coin_ack = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("stray_ack_busy", bus.busy, 0);
    check("stray_ack_valid", bus.coin_valid, 0);
    check("stray_ack_count", bus.coin_count, 3);
    check("stray_ack_done", bus.done, 0);
    bus.coin_ack = 1'b0;

    // Reset after the first coin of a 20/5 transaction.
    @(negedge clock);
    bus.req   = 1'b1;
    bus.paid  = 5'd20;
    bus.price = 5'd5;
    @(negedge clock);
    bus.req   = 1'b0;
    @(negedge clock);
    check("mid_first_value", bus.coin_value, 10);
    bus.coin_ack = 1'b1;
    @(negedge clock);
    bus.coin_ack = 1'b0;
    check("mid_second_value", bus.coin_value, 5);
    check("mid_count", bus.coin_count, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.coin_valid, 0);
    check("mid_rst_value", bus.coin_value, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_refunded", bus.refunded, 0);
    check("mid_rst_count", bus.coin_count, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("post_rst_done", bus.done, 0);
      check("post_rst_busy", bus.busy, 0);
    end
    run_txn(vecs[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
